// File: rtl/gray_scan_scheduler.sv
// gray_scan_scheduler: periodically scans CHANNELS Gray inputs through one shared external decoder.
// Define STABLE_CHECK_EN to publish a channel only when two consecutive scans sample the same raw value.
module gray_scan_scheduler #(
   parameter int WIDTH       = 4,
   parameter int CHANNELS    = 4,
   parameter int SCAN_PERIOD = 2700000
) (
   input  logic                      clk_i,
   input  logic                      rst_i,
   input  logic                      enable_i,
   input  logic [CHANNELS*WIDTH-1:0] gray_i,
   output logic [WIDTH-1:0]          dec_gray_o,
   input  logic [WIDTH-1:0]          dec_bin_i,
   output logic [CHANNELS*WIDTH-1:0] bin_o,
   output logic [CHANNELS-1:0]       valid_o,
   output logic                      scan_done_o,
   output logic                      busy_o,
   output logic                      overrun_o
);
   localparam int IW = $clog2(CHANNELS);
   localparam int CW = $clog2(SCAN_PERIOD);
   localparam logic [1:0] IDLE   = 2'd0;
   localparam logic [1:0] SAMPLE = 2'd1;
   localparam logic [1:0] DECODE = 2'd2;
   localparam logic [1:0] DONE   = 2'd3;

   logic [1:0]                state_q, state_d;
   logic [IW-1:0]             idx_q, idx_d;
   logic [WIDTH-1:0]          sample_q, sample_d;
   logic [CW-1:0]             cnt_q, cnt_d;
   logic                      tick_q, tick_d;
   logic [CHANNELS*WIDTH-1:0] bin_q, bin_d;
   logic [CHANNELS-1:0]       valid_q, valid_d;
   logic                      done_q, done_d;
   logic                      ovr_q, ovr_d;
   logic                      last, upd;

   assign last        = idx_q == IW'(CHANNELS - 1);
   assign dec_gray_o  = sample_q;
   assign bin_o       = bin_q;
   assign valid_o     = valid_q;
   assign scan_done_o = done_q;
   assign busy_o      = state_q != IDLE;
   assign overrun_o   = ovr_q;
   assign cnt_d       = (cnt_q == '0) ? CW'(SCAN_PERIOD - 1) : cnt_q - 1'b1;
   assign tick_d      = cnt_q == '0;

`ifdef STABLE_CHECK_EN
   logic [CHANNELS-1:0][WIDTH-1:0] raw_q, raw_d;
   assign upd = sample_q == raw_q[idx_q];
   always_comb begin
      raw_d = raw_q;
      if (state_q == DECODE) raw_d[idx_q] = sample_q;
   end
   always_ff @(posedge clk_i or negedge rst_i)
      if (!rst_i) raw_q <= '0;
      else        raw_q <= raw_d;
`else
   assign upd = 1'b1;
`endif

   always_comb begin
      state_d  = state_q;
      idx_d    = idx_q;
      sample_d = sample_q;
      bin_d    = bin_q;
      valid_d  = '0;
      done_d   = 1'b0;
      ovr_d    = ovr_q | (tick_q & busy_o);
      case (state_q)
         IDLE: if (tick_q && enable_i) begin
            state_d = SAMPLE;
            idx_d   = '0;
         end
         SAMPLE: begin
            sample_d = gray_i[idx_q*WIDTH +: WIDTH];
            state_d  = DECODE;
         end
         DECODE: begin
            if (upd) begin
               bin_d[idx_q*WIDTH +: WIDTH] = dec_bin_i;
               valid_d[idx_q]              = 1'b1;
            end
            state_d = last ? DONE : SAMPLE;
            idx_d   = last ? '0 : idx_q + 1'b1;
         end
         default: begin
            done_d  = 1'b1;
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         state_q  <= IDLE;
         idx_q    <= '0;
         sample_q <= '0;
         cnt_q    <= CW'(SCAN_PERIOD - 1);
         tick_q   <= 1'b0;
         bin_q    <= '0;
         valid_q  <= '0;
         done_q   <= 1'b0;
         ovr_q    <= 1'b0;
      end else begin
         state_q  <= state_d;
         idx_q    <= idx_d;
         sample_q <= sample_d;
         cnt_q    <= cnt_d;
         tick_q   <= tick_d;
         bin_q    <= bin_d;
         valid_q  <= valid_d;
         done_q   <= done_d;
         ovr_q    <= ovr_d;
      end
   end
endmodule

// File: tb/tb_gray_scan_scheduler.sv
// tb_gray_scan_scheduler: cycle-indexed vector table for the scan scheduler plus a short-period
// instance that must flag overrun; hand sequences cover async reset and the debounce build.
module tb_gray_scan_scheduler;
   logic        clk = 1'b0, rst_i = 1'b0, en = 1'b1;
   logic [15:0] gray = 16'h8C30;
   logic [3:0]  dg, db, odg, odb;
   logic [15:0] bin, obin;
   logic [3:0]  valid, ovalid;
   logic        done, busy, ovr, odone, obusy, oovr;
   int          cyc = 0, nvec = 0, nerr = 0;

   typedef struct {
      int          cyc;
      logic        en;
      logic [15:0] gray;
      logic        busy;
      logic [3:0]  valid;
      logic        done;
      logic [15:0] bin;
      logic        ob_chk;
      logic        obusy;
      logic        oovr;
   } vec_t;
   vec_t vec[$];

   function automatic logic [3:0] g2b(input logic [3:0] g);
      logic [3:0] b;
      for (int i = 0; i < 4; i++) b[i] = ^(g >> i);
      return b;
   endfunction

   assign db  = g2b(dg);
   assign odb = g2b(odg);

   always #5 clk = ~clk;

   gray_scan_scheduler #(.WIDTH(4), .CHANNELS(4), .SCAN_PERIOD(16)) dut (
      .clk_i(clk), .rst_i(rst_i), .enable_i(en), .gray_i(gray), .dec_gray_o(dg), .dec_bin_i(db),
      .bin_o(bin), .valid_o(valid), .scan_done_o(done), .busy_o(busy), .overrun_o(ovr));

   gray_scan_scheduler #(.WIDTH(4), .CHANNELS(4), .SCAN_PERIOD(8)) u_ovr (
      .clk_i(clk), .rst_i(rst_i), .enable_i(en), .gray_i(gray), .dec_gray_o(odg), .dec_bin_i(odb),
      .bin_o(obin), .valid_o(ovalid), .scan_done_o(odone), .busy_o(obusy), .overrun_o(oovr));

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      nvec++;
      if (act !== exp) begin
         nerr++;
         $display("FAIL %s @cyc %0d: got %h expected %h", name, cyc, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
      cyc++;
   endtask

   task automatic add(input int c, input logic e, input logic [15:0] g, input logic b,
                      input logic [3:0] v, input logic d, input logic [15:0] bn,
                      input logic oc, input logic ob, input logic oo);
      vec_t t;
      t.cyc = c; t.en = e; t.gray = g; t.busy = b; t.valid = v; t.done = d; t.bin = bn;
      t.ob_chk = oc; t.obusy = ob; t.oovr = oo;
      vec.push_back(t);
   endtask

   task automatic run(input int lo, input int hi);
      for (int i = lo; i < hi; i++) begin
         while (cyc < vec[i].cyc) step();
         chk($sformatf("busy[%0d]", i), 32'(busy), 32'(vec[i].busy));
         chk($sformatf("valid[%0d]", i), 32'(valid), 32'(vec[i].valid));
         chk($sformatf("done[%0d]", i), 32'(done), 32'(vec[i].done));
         chk($sformatf("bin[%0d]", i), 32'(bin), 32'(vec[i].bin));
         chk($sformatf("overrun[%0d]", i), 32'(ovr), 32'd0);
         chk($sformatf("ovr_overrun[%0d]", i), 32'(oovr), 32'(vec[i].oovr));
         if (vec[i].ob_chk) chk($sformatf("ovr_busy[%0d]", i), 32'(obusy), 32'(vec[i].obusy));
         en   = vec[i].en;
         gray = vec[i].gray;
      end
   endtask

   task automatic release_rst();
      @(negedge clk);
      rst_i = 1'b1;
      cyc   = 0;
   endtask

   initial begin
      // cyc en gray busy valid done bin ob_chk obusy oovr
      add( 8, 1, 16'h8C30, 0, 4'h0, 0, 16'h0000, 1, 0, 0);
      add( 9, 1, 16'h8C30, 0, 4'h0, 0, 16'h0000, 1, 1, 0);
      add(16, 1, 16'h8C30, 0, 4'h0, 0, 16'h0000, 1, 1, 0);
      add(17, 1, 16'h8C30, 1, 4'h0, 0, 16'h0000, 1, 1, 1);
      add(18, 1, 16'h8C30, 1, 4'h0, 0, 16'h0000, 1, 0, 1);
      add(19, 1, 16'h8C30, 1, 4'h1, 0, 16'h0000, 1, 0, 1);
      add(21, 1, 16'h8C30, 1, 4'h2, 0, 16'h0020, 0, 0, 1);
      add(23, 1, 16'h8C30, 1, 4'h4, 0, 16'h0820, 0, 0, 1);
      add(25, 1, 16'h8C30, 1, 4'h8, 0, 16'hF820, 0, 0, 1);
      add(26, 1, 16'h8C30, 0, 4'h0, 1, 16'hF820, 0, 0, 1);
      add(27, 1, 16'h8C30, 0, 4'h0, 0, 16'hF820, 0, 0, 1);
      add(32, 1, 16'h8C30, 0, 4'h0, 0, 16'hF820, 0, 0, 1);
      add(33, 1, 16'h8C30, 1, 4'h0, 0, 16'hF820, 0, 0, 1);
      add(41, 1, 16'h8C30, 1, 4'h8, 0, 16'hF820, 0, 0, 1);
      add(42, 0, 16'h0000, 0, 4'h0, 1, 16'hF820, 0, 0, 1);
      add(49, 0, 16'h0000, 0, 4'h0, 0, 16'hF820, 0, 0, 1);
      add(51, 0, 16'h0000, 0, 4'h0, 0, 16'hF820, 0, 0, 1);
      add(60, 1, 16'hA5F1, 0, 4'h0, 0, 16'hF820, 0, 0, 1);
      add(65, 1, 16'hA5F1, 1, 4'h0, 0, 16'hF820, 0, 0, 1);
      add(67, 0, 16'hA5F1, 1, 4'h1, 0, 16'hF821, 0, 0, 1);
      add(69, 0, 16'hA5F1, 1, 4'h2, 0, 16'hF8A1, 0, 0, 1);
      add(71, 0, 16'hA5F1, 1, 4'h4, 0, 16'hF6A1, 0, 0, 1);
      add(73, 0, 16'hA5F1, 1, 4'h8, 0, 16'hC6A1, 0, 0, 1);
      add(74, 0, 16'hA5F1, 0, 4'h0, 1, 16'hC6A1, 0, 0, 1);
      add(81, 1, 16'h8C30, 0, 4'h0, 0, 16'hC6A1, 0, 0, 1);
      add(101, 1, 16'h8C30, 1, 4'h2, 0, 16'hC620, 0, 0, 1);
`ifndef STABLE_CHECK_EN
      #2;
      chk("rst_bin", 32'(bin), 32'd0);
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_dec_gray", 32'(dg), 32'd0);
      release_rst();
      run(0, vec.size());
      while (cyc < 102) step();
      #2;
      rst_i = 1'b0;
      #1;
      chk("async_bin", 32'(bin), 32'd0);
      chk("async_busy", 32'(busy), 32'd0);
      chk("async_valid", 32'(valid), 32'd0);
      chk("async_done", 32'(done), 32'd0);
      chk("async_dec_gray", 32'(dg), 32'd0);
      chk("async_ovr_overrun", 32'(oovr), 32'd0);
      @(posedge clk);
      release_rst();
      run(0, 11);
`else
      gray = 16'h0000;
      release_rst();
      while (cyc < 19) step();
      chk("st_valid0_first", 32'(valid), 32'h1);
      while (cyc < 26) step();
      chk("st_done_first", 32'(done), 32'd1);
      gray = 16'h0006;
      while (cyc < 35) step();
      chk("st_valid0_held", 32'(valid), 32'h0);
      chk("st_bin0_held", 32'(bin[3:0]), 32'h0);
      while (cyc < 42) step();
      chk("st_done_second", 32'(done), 32'd1);
      while (cyc < 51) step();
      chk("st_valid0_pub", 32'(valid), 32'h1);
      chk("st_bin0_pub", 32'(bin), 32'h0004);
`endif
      $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
      $finish;
   end
endmodule
